// File: rtl/gcd_binary_n.sv
// Binary (Stein) GCD engine: one operand pair in flight, valid/ready on both sides.
// Latency: accept edge to out_valid is at most 4*WIDTH+4 cycles; exactly 3 when a==b and both are odd.
// Backpressure: the result holds in DONE until out_ready; in_ready is high only in IDLE.
module gcd_binary_n #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] dout,
    output logic             busy
);

    localparam int KW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CHECK = 3'd1,
        S_EVEN  = 3'd2,
        S_ODD   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  x_q, x_d;
    logic [WIDTH-1:0]  y_q, y_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic [KW-1:0]     k_q, k_d;
    logic              rdy_q, rdy_d;

    // rdy_q keeps in_ready low while reset is held and for the release edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            res_q   <= '0;
            k_q     <= '0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            res_q   <= res_d;
            k_q     <= k_d;
            rdy_q   <= rdy_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        res_d     = res_q;
        k_d       = k_q;
        rdy_d     = 1'b1;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;

        case (state_q)
            S_IDLE: begin
                busy     = 1'b0;
                in_ready = rdy_q;
                if (in_valid && rdy_q) begin
                    x_d     = a;
                    y_d     = b;
                    k_d     = '0;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (x_q == '0) begin
                    res_d   = y_q;
                    state_d = S_DONE;
                end else if (y_q == '0) begin
                    res_d   = x_q;
                    state_d = S_DONE;
                end else begin
                    state_d = S_EVEN;
                end
            end
            S_EVEN: begin
                if (!x_q[0] && !y_q[0]) begin
                    x_d = x_q >> 1;
                    y_d = y_q >> 1;
                    k_d = k_q + KW'(1);
                end else begin
                    state_d = S_ODD;
                end
            end
            S_ODD: begin
                // Larger operand is always the minuend, so the subtraction cannot wrap.
                if (!x_q[0]) begin
                    x_d = x_q >> 1;
                end else if (!y_q[0]) begin
                    y_d = y_q >> 1;
                end else if (x_q == y_q) begin
                    res_d   = x_q << k_q;
                    state_d = S_DONE;
                end else if (x_q > y_q) begin
                    x_d = x_q - y_q;
                end else begin
                    y_d = y_q - x_q;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign dout = res_q;

endmodule

// File: tb/tb_gcd_binary_n.sv
// Scoreboard bench for gcd_binary_n: a 16-bit instance for directed vectors, an 8-bit instance for random pairs.
module tb_gcd_binary_n;

    logic        clk;
    logic        reset;
    logic        in_valid16, in_ready16, out_valid16, out_ready16, busy16;
    logic [15:0] a16, b16, dout16;
    logic        in_valid8, in_ready8, out_valid8, out_ready8, busy8;
    logic [7:0]  a8, b8, dout8;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        logic [15:0] val;
        int          acc;
        int          lat_max;
        int          lat_exact;
    } exp_t;

    exp_t q16[$];
    exp_t q8[$];

    gcd_binary_n #(.WIDTH(16)) dut16 (
        .clk(clk), .reset(reset), .in_valid(in_valid16), .in_ready(in_ready16),
        .a(a16), .b(b16), .out_valid(out_valid16), .out_ready(out_ready16),
        .dout(dout16), .busy(busy16)
    );

    gcd_binary_n #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .dout(dout8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic int unsigned euclid(input int unsigned x, input int unsigned y);
        int unsigned t;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Monitor for the 16-bit instance: latency, stability, value, and in_ready after handshake.
    logic        seen16 = 1'b0, rchk16 = 1'b0;
    logic [15:0] held16;
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            seen16 = 1'b0;
            rchk16 = 1'b0;
        end else begin
            if (rchk16) begin
                chk("in_ready_after_hs16", int'(in_ready16), 1);
                rchk16 = 1'b0;
            end
            if (out_valid16) begin
                if (q16.size() == 0) begin
                    chk("spurious_out16", int'(out_valid16), 0);
                end else begin
                    if (!seen16) begin
                        if (q16[0].lat_exact >= 0)
                            chk("latency_exact16", cyc - q16[0].acc, q16[0].lat_exact);
                        else
                            chk("latency_bound16", int'((cyc - q16[0].acc) <= q16[0].lat_max), 1);
                        seen16 = 1'b1;
                        held16 = dout16;
                    end else begin
                        chk("dout_stable16", int'(dout16), int'(held16));
                    end
                    if (out_ready16) begin
                        chk("dout16", int'(dout16), int'(q16[0].val));
                        void'(q16.pop_front());
                        seen16 = 1'b0;
                        rchk16 = 1'b1;
                    end
                end
            end
        end
    end

    logic seen8 = 1'b0, rchk8 = 1'b0;
    always @(negedge clk) begin
        #1;
        if (!reset) begin
            seen8 = 1'b0;
            rchk8 = 1'b0;
        end else begin
            if (rchk8) begin
                chk("in_ready_after_hs8", int'(in_ready8), 1);
                rchk8 = 1'b0;
            end
            if (out_valid8) begin
                if (q8.size() == 0) begin
                    chk("spurious_out8", int'(out_valid8), 0);
                end else begin
                    if (!seen8) begin
                        chk("latency_bound8", int'((cyc - q8[0].acc) <= q8[0].lat_max), 1);
                        seen8 = 1'b1;
                    end
                    if (out_ready8) begin
                        chk("dout8", int'(dout8), int'(q8[0].val));
                        void'(q8.pop_front());
                        seen8 = 1'b0;
                        rchk8 = 1'b1;
                    end
                end
            end
        end
    end

    task automatic send16(input logic [15:0] av, input logic [15:0] bv, input logic [15:0] ev,
                          input int lmax, input int lex);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        in_valid16 = 1'b1;
        a16 = av;
        b16 = bv;
        while (!in_ready16 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout16", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid16 = 1'b0;
        e.val = ev; e.acc = cyc; e.lat_max = lmax; e.lat_exact = lex;
        q16.push_back(e);
    endtask

    task automatic wait_done16();
        int n = 0;
        while (q16.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300) begin
            chk("result_timeout16", 0, 1);
            q16.delete();
        end
        @(negedge clk);
    endtask

    task automatic send8(input logic [7:0] av, input logic [7:0] bv);
        exp_t e;
        int   n = 0;
        @(negedge clk);
        in_valid8 = 1'b1;
        a8 = av;
        b8 = bv;
        while (!in_ready8 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("accept_timeout8", 0, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid8 = 1'b0;
        e.val = 16'(euclid(av, bv)); e.acc = cyc; e.lat_max = 36; e.lat_exact = -1;
        q8.push_back(e);
        n = 0;
        while (q8.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            chk("result_timeout8", 0, 1);
            q8.delete();
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0;
        in_valid16 = 1'b0; a16 = '0; b16 = '0; out_ready16 = 1'b1;
        in_valid8  = 1'b0; a8  = '0; b8  = '0; out_ready8  = 1'b1;
        #23;
        chk("rst_out_valid", int'(out_valid16), 0);
        chk("rst_busy",      int'(busy16), 0);
        chk("rst_dout",      int'(dout16), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", int'(in_ready16), 1);
        chk("rel_busy",     int'(busy16), 0);

        send16(16'd48, 16'd18, 16'd6, 68, -1);        wait_done16();
        send16(16'd0, 16'd35, 16'd35, 2, -1);         wait_done16();
        send16(16'd35, 16'd0, 16'd35, 2, -1);         wait_done16();
        send16(16'd0, 16'd0, 16'd0, 2, -1);           wait_done16();
        chk("dout_holds_after_done", int'(dout16), 0);
        send16(16'd32768, 16'd1024, 16'd1024, 68, -1); wait_done16();
        send16(16'd65535, 16'd65535, 16'd65535, 68, 3); wait_done16();
        chk("dout_holds_idle", int'(dout16), 65535);
        chk("idle_busy", int'(busy16), 0);

        // Backpressure with ignored input pulses while DONE is held.
        out_ready16 = 1'b0;
        send16(16'd1071, 16'd462, 16'd21, 68, -1);
        n = 0;
        while (!out_valid16 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("bp_timeout", 0, 1);
        repeat (10) begin
            @(negedge clk);
            in_valid16 = 1'b1;
            a16 = 16'd5;
            b16 = 16'd5;
            #1;
            chk("bp_in_ready", int'(in_ready16), 0);
            chk("bp_out_valid", int'(out_valid16), 1);
            chk("bp_dout", int'(dout16), 21);
        end
        @(negedge clk);
        in_valid16 = 1'b0;
        out_ready16 = 1'b1;
        wait_done16();
        chk("bp_busy_after", int'(busy16), 0);

        // Abort mid-computation.
        send16(16'd60000, 16'd7, 16'd1, 68, -1);
        repeat (10) @(negedge clk);
        chk("pre_abort_busy", int'(busy16), 1);
        reset = 1'b0;
        #1;
        q16.delete();
        chk("abort_out_valid", int'(out_valid16), 0);
        chk("abort_busy", int'(busy16), 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_abort_in_ready", int'(in_ready16), 1);
        chk("post_abort_out_valid", int'(out_valid16), 0);
        send16(16'd9, 16'd6, 16'd3, 68, -1);          wait_done16();

        // 8-bit instance: random pairs against a Euclid model, zeros forced on a few.
        for (int i = 0; i < 1000; i++) begin
            logic [7:0] ra, rb;
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            if (i % 97 == 0) ra = 8'd0;
            if (i % 89 == 1) rb = 8'd0;
            send8(ra, rb);
        end
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
